// File: rtl/pipelined_alu_core_if.sv
// Instruction/result bundle for pipelined_alu_core.
// Both directions are valid/ready: a transfer happens on a rising edge where valid && ready
// are both high; the sender holds its payload steady while valid is high and ready is low.
interface pipelined_alu_core_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic [REG_AW-1:0] rwa;
  logic [MEM_AW-1:0] ma;
  logic [3:0]        func;
  logic              reg_we;
  logic              mem_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, ra1, ra2, rwa, ma, func, reg_we, mem_we, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, ra1, ra2, rwa, ma, func, reg_we, mem_we, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipelined_alu_core.sv
// Four-stage ALU: operand fetch, execute with forwarding, register writeback, memory write/output.
// The whole pipe moves as one; a stalled output freezes every stage.
module pipelined_alu_core #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pipelined_alu_core_if.slave bus,
  input  logic [MEM_AW-1:0]   dbg_ma,
  output logic [DATA_W-1:0]   dbg_rdata,
  output logic                illegal_op
);
  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] rwa;
    logic [MEM_AW-1:0] ma;
    logic [3:0]        func;
    logic              reg_we;
    logic              mem_we;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fetch_t;

  // Write enables here are already cleared for illegal instructions.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rwa;
    logic [MEM_AW-1:0] ma;
    logic              reg_we;
    logic              mem_we;
    logic [DATA_W-1:0] res;
  } result_t;

  fetch_t            s1_q, s1_d;
  result_t           s3_q, s3_d;
  result_t           s4_q, s4_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] regbank_q [NREG];
  logic [DATA_W-1:0] mem_q [NMEM];

  logic              advance;
  logic              accept;
  logic              reg_wr;
  logic              mem_wr;
  logic              is_illegal;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;

  always_comb begin
    advance = !s4_q.valid || bus.out_ready;
    accept  = bus.in_valid && advance;
    reg_wr  = advance && s3_q.valid && s3_q.reg_we;
    mem_wr  = s4_q.valid && bus.out_ready && s4_q.mem_we;
  end

  // The youngest producer wins, so S3 is tested before S4.
  always_comb begin
    op_a = s1_q.a;
    if (s3_q.valid && s3_q.reg_we && (s3_q.rwa == s1_q.ra1)) begin
      op_a = s3_q.res;
    end else if (s4_q.valid && s4_q.reg_we && (s4_q.rwa == s1_q.ra1)) begin
      op_a = s4_q.res;
    end
    op_b = s1_q.b;
    if (s3_q.valid && s3_q.reg_we && (s3_q.rwa == s1_q.ra2)) begin
      op_b = s3_q.res;
    end else if (s4_q.valid && s4_q.reg_we && (s4_q.rwa == s1_q.ra2)) begin
      op_b = s4_q.res;
    end
  end

  always_comb begin
    alu_res    = '0;
    is_illegal = 1'b0;
    case (s1_q.func)
      4'h0:    alu_res = op_a + op_b;
      4'h1:    alu_res = op_a - op_b;
      4'h2:    alu_res = op_a * op_b;
      4'h3:    alu_res = op_a;
      4'h4:    alu_res = op_b;
      4'h5:    alu_res = op_a & op_b;
      4'h6:    alu_res = op_a | op_b;
      4'h7:    alu_res = op_a ^ op_b;
      4'h8:    alu_res = ~(op_a ^ op_b);
      4'h9:    alu_res = ~op_a;
      4'hA:    alu_res = ~op_b;
      4'hB:    alu_res = op_a >> 1;
      4'hC:    alu_res = op_a << 1;
      4'hD:    alu_res = {op_a[DATA_W-1], op_a[DATA_W-1:1]};
      4'hE:    alu_res = {op_a[DATA_W-2:0], op_a[DATA_W-1]};
      default: is_illegal = 1'b1;
    endcase
  end

  always_comb begin
    s1_d      = s1_q;
    s3_d      = s3_q;
    s4_d      = s4_q;
    illegal_d = illegal_q;
    if (advance) begin
      s1_d.valid  = accept;
      s1_d.ra1    = bus.ra1;
      s1_d.ra2    = bus.ra2;
      s1_d.rwa    = bus.rwa;
      s1_d.ma     = bus.ma;
      s1_d.func   = bus.func;
      s1_d.reg_we = bus.reg_we;
      s1_d.mem_we = bus.mem_we;
      s1_d.a      = regbank_q[bus.ra1];
      s1_d.b      = regbank_q[bus.ra2];

      s3_d.valid  = s1_q.valid;
      s3_d.rwa    = s1_q.rwa;
      s3_d.ma     = s1_q.ma;
      s3_d.reg_we = s1_q.reg_we && !is_illegal;
      s3_d.mem_we = s1_q.mem_we && !is_illegal;
      s3_d.res    = alu_res;

      s4_d      = s3_q;
      illegal_d = illegal_q || (s1_q.valid && is_illegal);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s3_q      <= '0;
      s4_q      <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regbank_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s3_q      <= s3_d;
      s4_q      <= s4_d;
      illegal_q <= illegal_d;
      if (reg_wr) begin
        regbank_q[s3_q.rwa] <= s3_q.res;
      end
    end
  end

  // Memory keeps its contents through reset; only the write is blocked.
  always_ff @(posedge clk) begin
    if (rst_n && mem_wr) begin
      mem_q[s4_q.ma] <= s4_q.res;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = s4_q.valid;
  assign bus.out_data  = s4_q.res;
  assign illegal_op    = illegal_q;
  assign dbg_rdata     = mem_q[dbg_ma];
endmodule

// File: tb/tb_pipelined_alu_core.sv
// Bench for pipelined_alu_core: directed latency/forwarding/stall/illegal/reset scenarios,
// randomized traffic against an in-order instruction-level model, and an 8-bit build.
module tb_pipelined_alu_core;
  logic       clk;
  logic       rst_n;
  logic [7:0] dbg_ma;
  logic [15:0] dbg_rdata;
  logic       illegal_op;
  logic [7:0] dbg_ma8;
  logic [7:0] dbg_rdata8;
  logic       illegal8;

  pipelined_alu_core_if #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) bus ();
  pipelined_alu_core_if #(.DATA_W(8),  .REG_AW(4), .MEM_AW(8)) bus8 ();

  pipelined_alu_core #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dbg_ma(dbg_ma), .dbg_rdata(dbg_rdata), .illegal_op(illegal_op)
  );

  pipelined_alu_core #(.DATA_W(8), .REG_AW(4), .MEM_AW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8),
    .dbg_ma(dbg_ma8), .dbg_rdata(dbg_rdata8), .illegal_op(illegal8)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // reference model and scoreboard
  int          n_tests = 0;
  int          n_fail  = 0;
  string       cur_tag = "reset";
  bit          rand_mode = 1'b0;
  logic [15:0] mreg [16];
  logic [15:0] mmem [256];
  bit          mknown [256];
  bit          ill_exp = 1'b0;
  logic [24:0] exp_q [$];   // {mem_we, ma, result}
  logic [7:0]  got8 [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_ref(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua;
    int unsigned ub;
    ua = a;
    ub = b;
    case (f)
      4'h0: return 16'(ua + ub);
      4'h1: return 16'(ua - ub);
      4'h2: return 16'(ua * ub);
      4'h3: return a;
      4'h4: return b;
      4'h5: return a & b;
      4'h6: return a | b;
      4'h7: return a ^ b;
      4'h8: return ~(a ^ b);
      4'h9: return ~a;
      4'hA: return ~b;
      4'hB: return 16'(ua / 2);
      4'hC: return 16'(ua * 2);
      4'hD: return 16'(ua / 2 + ((ua >= 32768) ? 32768 : 0));
      4'hE: return 16'(ua * 2 + ua / 32768);
      default: return 16'h0;
    endcase
  endfunction

  always @(negedge clk) begin : mon
    logic [24:0] ent;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("out_unexpected", exp_q.size(), 1);
      end else begin
        ent = exp_q.pop_front();
        check_eq(cur_tag, bus.out_data, ent[15:0]);
        if (ent[24]) begin
          mmem[ent[23:16]]   = ent[15:0];
          mknown[ent[23:16]] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus8.out_valid && bus8.out_ready) got8.push_back(bus8.out_data);
  end

  // driver tasks: every task returns 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] w, input logic [7:0] m, input logic rwe, input logic mwe);
    logic        acc;
    logic [15:0] res;
    logic        mw;
    int          n;
    bus.in_valid = 1'b1;
    bus.func     = f;
    bus.ra1      = a1;
    bus.ra2      = a2;
    bus.rwa      = w;
    bus.ma       = m;
    bus.reg_we   = rwe;
    bus.mem_we   = mwe;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) begin
        if (f == 4'hF) begin
          res     = 16'h0;
          mw      = 1'b0;
          ill_exp = 1'b1;
        end else begin
          res = alu_ref(f, mreg[a1], mreg[a2]);
          mw  = mwe;
          if (rwe) mreg[w] = res;
        end
        exp_q.push_back({mw, m, res});
      end
      tick();
      n++;
    end
    if (!acc) check_eq("accept_timeout", acc, 1);
  endtask

  task automatic drain();
    int n;
    rand_mode     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  task automatic check_mem(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      if (mknown[a]) begin
        dbg_ma = 8'(a);
        @(negedge clk);
        check_eq("mem_rd", dbg_rdata, mmem[a]);
      end
    end
    tick();
  endtask

  task automatic issue8(input logic [3:0] f, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w);
    bus8.in_valid = 1'b1;
    bus8.func     = f;
    bus8.ra1      = a1;
    bus8.ra2      = a2;
    bus8.rwa      = w;
    bus8.reg_we   = 1'b1;
    tick();
  endtask

  // main sequence
  initial begin
    bus.in_valid = 1'b0; bus.func = 4'h0; bus.ra1 = 4'h0; bus.ra2 = 4'h0; bus.rwa = 4'h0;
    bus.ma = 8'h0; bus.reg_we = 1'b0; bus.mem_we = 1'b0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.func = 4'h0; bus8.ra1 = 4'h0; bus8.ra2 = 4'h0; bus8.rwa = 4'h0;
    bus8.ma = 8'h0; bus8.reg_we = 1'b0; bus8.mem_we = 1'b0; bus8.out_ready = 1'b1;
    dbg_ma = 8'h0; dbg_ma8 = 8'h0;
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_illegal", illegal_op, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    tick();

    // r1 = 5, r2 = 3 built from the zeroed bank; mem[0x10] = 5 on the way
    cur_tag = "build";
    issue(4'h9, 0, 0, 1, 8'h00, 1, 0);
    issue(4'h1, 0, 1, 1, 8'h00, 1, 0);
    issue(4'hC, 1, 0, 2, 8'h00, 1, 0);
    issue(4'hC, 2, 0, 2, 8'h00, 1, 0);
    issue(4'h1, 2, 1, 3, 8'h00, 1, 0);
    issue(4'h0, 2, 1, 1, 8'h10, 1, 1);
    issue(4'h3, 3, 0, 2, 8'h00, 1, 0);
    drain();
    dbg_ma = 8'h10;
    @(negedge clk);
    check_eq("build_mem10", dbg_rdata, 5);
    tick();

    cur_tag = "latency";
    issue(4'h0, 1, 2, 3, 8'h10, 1, 1);
    bus.in_valid = 1'b0;
    @(negedge clk); check_eq("lat_e0_valid", bus.out_valid, 0); tick();
    @(negedge clk); check_eq("lat_e1_valid", bus.out_valid, 0); tick();
    @(negedge clk);
    check_eq("lat_e2_valid", bus.out_valid, 1);
    check_eq("lat_e2_data", bus.out_data, 8);
    check_eq("lat_mem_old", dbg_rdata, 5);
    tick();
    @(negedge clk); check_eq("lat_mem_new", dbg_rdata, 8); tick();

    cur_tag = "fwd_s3";
    issue(4'h7, 1, 1, 3, 8'h00, 1, 0);
    drain();
    issue(4'h0, 1, 2, 3, 8'h00, 1, 0);
    issue(4'h1, 3, 1, 4, 8'h00, 1, 0);
    drain();
    cur_tag = "fwd_s4";
    issue(4'h7, 1, 1, 3, 8'h00, 1, 0);
    drain();
    issue(4'h0, 1, 2, 3, 8'h00, 1, 0);
    bus.in_valid = 1'b0;
    tick();
    issue(4'h1, 3, 1, 4, 8'h00, 1, 0);
    drain();

    cur_tag = "stall";
    bus.out_ready = 1'b0;
    dbg_ma = 8'h10;
    issue(4'h3, 1, 0, 9, 8'h10, 1, 1);
    issue(4'h0, 9, 9, 10, 8'h00, 1, 0);
    issue(4'h1, 10, 1, 11, 8'h00, 1, 0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("stall_in_ready", bus.in_ready, 0);
      check_eq("stall_out_valid", bus.out_valid, 1);
      check_eq("stall_out_data", bus.out_data, 5);
      check_eq("stall_mem_hold", dbg_rdata, 8);
      tick();
    end
    drain();
    check_mem(16, 16);

    cur_tag = "illegal";
    issue(4'hF, 1, 2, 1, 8'h10, 1, 1);
    drain();
    check_eq("illegal_set", illegal_op, 1);
    issue(4'h3, 1, 0, 12, 8'h00, 1, 0);
    drain();
    check_eq("illegal_sticky", illegal_op, 1);
    check_mem(16, 16);

    cur_tag = "reset_flight";
    issue(4'h0, 1, 2, 5, 8'h10, 1, 1);
    issue(4'h7, 1, 2, 6, 8'h10, 1, 1);
    issue(4'h9, 1, 0, 7, 8'h10, 1, 1);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = 16'h0;
    exp_q.delete();
    ill_exp = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstf_out_valid", bus.out_valid, 0);
    check_eq("rstf_in_ready", bus.in_ready, 1);
    check_eq("rstf_illegal", illegal_op, 0);
    tick();
    check_mem(16, 16);
    cur_tag = "reset_regs";
    issue(4'h3, 5, 0, 0, 8'h00, 0, 0);
    issue(4'h3, 6, 0, 0, 8'h00, 0, 0);
    issue(4'h3, 7, 0, 0, 8'h00, 0, 0);
    issue(4'h3, 1, 0, 0, 8'h00, 0, 0);
    drain();

    cur_tag = "random";
    rand_mode = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 4) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end else begin
        issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 8'(8'h40 + $urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
    drain();
    check_mem(8'h40, 8'h47);
    check_mem(16, 16);
    check_eq("illegal_final", illegal_op, ill_exp);
    cur_tag = "regdump";
    for (int i = 0; i < 16; i++) issue(4'h3, 4'(i), 0, 0, 8'h00, 0, 0);
    drain();

    // 8-bit build: every instruction back-to-back, relying on forwarding
    issue8(4'h9, 0, 0, 1);
    issue8(4'h1, 0, 1, 2);
    issue8(4'hC, 1, 0, 3);
    for (int i = 0; i < 5; i++) issue8(4'hC, 3, 0, 3);
    issue8(4'hD, 3, 0, 4);
    issue8(4'hC, 2, 0, 5);
    for (int i = 0; i < 6; i++) issue8(4'hC, 5, 0, 5);
    issue8(4'h6, 5, 2, 5);
    issue8(4'hE, 5, 0, 6);
    issue8(4'hC, 2, 0, 7);
    for (int i = 0; i < 3; i++) issue8(4'hC, 7, 0, 7);
    issue8(4'h2, 7, 7, 8);
    bus8.in_valid = 1'b0;
    repeat (5) tick();
    check_eq("w8_count", got8.size(), 23);
    if (got8.size() == 23) begin
      check_eq("w8_c0", got8[7], 8'hC0);
      check_eq("w8_asr", got8[8], 8'hE0);
      check_eq("w8_81", got8[16], 8'h81);
      check_eq("w8_rol", got8[17], 8'h03);
      check_eq("w8_mul", got8[22], 8'h00);
    end
    check_eq("w8_illegal", illegal8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
